ikaopll_sample_accumulator: RTL and testbench
=============================================

Name: ikaopll_sample_accumulator

Overview:
- Downstream consumer of the timing generator's cycle strobes and melody/rhythm output controls.
- Each phi1 cycle it samples the operator output word and adds it to a melody accumulator, a rhythm accumulator, or neither.
- Once per 18-slot frame, marked by CYCLE_00, it dumps both totals and a weighted mix into output registers.
- Hands finished samples to the host side through a valid/ack handshake with overrun detection.

Parameters:
- OUT_WIDTH, 16, width of o_MIX; sign-extended from the 14-bit internal mix. Legal range 14..24.

Ports:
- i_EMUCLK  in  1  emulator master clock; the only clock.
- i_IC_n  in  1  reset; synchronous, active-low, sampled on every i_EMUCLK edge regardless of clock enables.
- i_phi1_NCEN_n  in  1  phi1 negative-edge clock enable, active-low. All accumulation and dump work happens only on enabled edges.
- i_CYCLE_00  in  1  frame-start strobe from the timing generator.
- i_MO_CTRL  in  1  current slot contributes to melody.
- i_RO_CTRL  in  1  current slot contributes to rhythm.
- i_RHYTHM_EN  in  1  rhythm mode; when 0, rhythm contributions are ignored.
- i_OP_OUT  in  9  operator output, two's complement, -256..255.
- i_SAMPLE_ACK  in  1  host consumed the sample; level, sampled every i_EMUCLK edge.
- o_MO  out  13  melody frame total, signed.
- o_RO  out  13  rhythm frame total, signed.
- o_MIX  out  OUT_WIDTH  o_MO + 2*o_RO, sign-extended.
- o_SAMPLE_VALID  out  1  an unconsumed sample is held.
- o_OVERRUN  out  1  sticky; a sample was overwritten before it was acknowledged.

Behaviour:
- Reset (i_IC_n=0 at an i_EMUCLK edge):
  - all outputs 0; both accumulators 0; state WAIT_SYNC.
  - Reset takes priority over ack and enables.
  - Reset mid-frame discards the partial frame.
- Contribution terms, sampled on an enabled edge (en = !i_phi1_NCEN_n):
  - melody term cm = i_MO_CTRL ? sext(i_OP_OUT) : 0
  - rhythm term cr = (i_RO_CTRL & i_RHYTHM_EN) ? sext(i_OP_OUT) : 0
  - MO_CTRL and RO_CTRL both high: the word feeds both accumulators.
- State WAIT_SYNC:
  - Enabled edges with i_CYCLE_00=0 are ignored; accumulators stay 0.
  - Enabled edge with i_CYCLE_00=1: acc_mo<=cm, acc_ro<=cr; go to ACCUM; no dump.
- State ACCUM, enabled edge with i_CYCLE_00=0: acc_mo+=cm, acc_ro+=cr.
- State ACCUM, enabled edge with i_CYCLE_00=1 (dump):
  - o_MO<=acc_mo; o_RO<=acc_ro.
  - o_MIX<=sext(acc_mo + (acc_ro<<1)), computed at 14 bits.
  - acc_mo<=cm, acc_ro<=cr; the current slot belongs to the new frame.
  - o_SAMPLE_VALID<=1.
- Dump latency: outputs visible the i_EMUCLK edge after the enabled edge carrying CYCLE_00.
- Arithmetic:
  - 13-bit two's complement; 9 contributions of 9-bit values cannot overflow.
  - Excess contributions wrap modulo 2^13 (see the optional feature for saturation).
- Handshake:
  - i_SAMPLE_ACK=1 with no dump on the same edge: o_SAMPLE_VALID<=0.
  - Dump and ack on the same edge: valid stays 1, no overrun.
  - Dump while valid=1 and ack=0: data overwritten, o_OVERRUN<=1. o_OVERRUN clears only on reset.
  - Ack while valid=0 has no effect.
- i_CYCLE_00 high on consecutive enabled edges: every such edge is a dump. The second dump holds only the first edge's terms.
- Disabled edges: no state change except the handshake logic.

Optional Feature:
- Macro: IKAOPLL_ACC_SATURATE_EN.
- Defined:
  - each accumulator add clamps to -4096..4095.
  - the 14-bit mix clamps to -8192..8191 before sign extension.
- Undefined: accumulators and mix wrap; no clamp logic is synthesised.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package ikaopll_pkg holds:
  - accumulator width constant ACC_W=13, MIX_W=14, OP_W=9
  - state enum {WAIT_SYNC, ACCUM}
  - sign-extend and saturate-add helper functions
- One sub-module, ikaopll_sat_acc:
  - one accumulator lane with load/add/clamp.
  - instantiated twice (melody, rhythm); clamp logic is conditional on the macro.

Test Plan:
- Reset, then a frame with MO_CTRL=1 on 9 slots, OP_OUT=+100 -> second CYCLE_00 gives o_MO=900, o_RO=0, o_MIX=900, o_SAMPLE_VALID=1.
- RHYTHM_EN=1, RO_CTRL=1 on 5 slots, OP_OUT=-50, MO_CTRL=0 -> o_RO=-250, o_MIX=-500. Repeat with RHYTHM_EN=0 -> o_RO=0.
- No ack across two dumps -> o_OVERRUN=1 stays 1 through later acks. Ack on the same edge as a dump -> valid stays 1, no overrun.
- 20 slots of MO_CTRL, OP_OUT=255 in one frame:
  - with the macro, o_MO=4095.
  - without it, o_MO = 5100 - 8192 = -3092.
- Slot at CYCLE_00 with OP_OUT=7, MO_CTRL=1, others 0 -> next dump o_MO=7. First CYCLE_00 after reset gives no valid.
- Assert i_IC_n=0 mid-frame, release -> outputs 0, WAIT_SYNC. The first dump occurs only at the second CYCLE_00 after release.

Source files
------------

// File: rtl/ikaopll_pkg.sv
// +------------------------------------------------------------------+
// | ikaopll_pkg : widths, state encoding and helpers shared by the    |
// | ikaopll sample accumulator.                  Revision: 1.0        |
// +------------------------------------------------------------------+
`default_nettype none

package ikaopll_pkg;

  localparam int ACC_W = 13;
  localparam int MIX_W = 14;
  localparam int OP_W  = 9;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    ACCUM     = 1'b1
  } acc_state_e;

  function automatic logic signed [ACC_W-1:0] sext_op(input logic [OP_W-1:0] v);
    return {{(ACC_W-OP_W){v[OP_W-1]}}, v};
  endfunction

  // Overflow shows up as disagreement between the guard bit and the sign bit.
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  function automatic logic signed [MIX_W-1:0] sat_mix(input logic signed [MIX_W:0] s);
    if (s[MIX_W] != s[MIX_W-1])
      return s[MIX_W] ? {1'b1, {(MIX_W-1){1'b0}}} : {1'b0, {(MIX_W-1){1'b1}}};
    return s[MIX_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ikaopll_sat_acc.sv
// +------------------------------------------------------------------+
// | ikaopll_sat_acc : one accumulator lane (load / add / optional     |
// | clamp when IKAOPLL_ACC_SATURATE_EN is defined). Revision: 1.0     |
// +------------------------------------------------------------------+
`default_nettype none

module ikaopll_sat_acc
  import ikaopll_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    en_i,
  input  logic                    load_i,
  input  logic                    add_i,
  input  logic signed [ACC_W-1:0] term_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] w_sum;

`ifdef IKAOPLL_ACC_SATURATE_EN
  assign w_sum = sat_add(acc_q, term_i);
`else
  assign w_sum = acc_q + term_i;
`endif

  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      if (load_i)
        acc_d = term_i;
      else if (add_i)
        acc_d = w_sum;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/ikaopll_sample_accumulator.sv
// +------------------------------------------------------------------+
// | ikaopll_sample_accumulator : per-frame melody/rhythm totals, mix  |
// | and valid/ack handoff. Option: IKAOPLL_ACC_SATURATE_EN. Rev: 1.0  |
// +------------------------------------------------------------------+
`default_nettype none

module ikaopll_sample_accumulator
  import ikaopll_pkg::*;
#(
  parameter int OUT_WIDTH = 16
) (
  input  logic                 i_EMUCLK,
  input  logic                 i_IC_n,
  input  logic                 i_phi1_NCEN_n,
  input  logic                 i_CYCLE_00,
  input  logic                 i_MO_CTRL,
  input  logic                 i_RO_CTRL,
  input  logic                 i_RHYTHM_EN,
  input  logic [OP_W-1:0]      i_OP_OUT,
  input  logic                 i_SAMPLE_ACK,
  output logic [ACC_W-1:0]     o_MO,
  output logic [ACC_W-1:0]     o_RO,
  output logic [OUT_WIDTH-1:0] o_MIX,
  output logic                 o_SAMPLE_VALID,
  output logic                 o_OVERRUN
);

  acc_state_e state_q;
  acc_state_e state_d;

  logic signed [ACC_W-1:0]     mo_q;
  logic signed [ACC_W-1:0]     ro_q;
  logic signed [OUT_WIDTH-1:0] mix_q;
  logic                        valid_q;
  logic                        ovr_q;

  logic                    w_en;
  logic                    w_dump;
  logic signed [ACC_W-1:0] w_cm;
  logic signed [ACC_W-1:0] w_cr;
  logic signed [ACC_W-1:0] w_acc_mo;
  logic signed [ACC_W-1:0] w_acc_ro;
  logic signed [MIX_W-1:0] w_mix;

  assign w_en   = !i_phi1_NCEN_n;
  assign w_dump = w_en && i_CYCLE_00 && (state_q == ACCUM);
  assign w_cm   = i_MO_CTRL ? sext_op(i_OP_OUT) : '0;
  assign w_cr   = (i_RO_CTRL && i_RHYTHM_EN) ? sext_op(i_OP_OUT) : '0;

`ifdef IKAOPLL_ACC_SATURATE_EN
  logic signed [MIX_W:0] w_mix_wide;
  assign w_mix_wide = (MIX_W+1)'(w_acc_mo) + ((MIX_W+1)'(w_acc_ro) <<< 1);
  assign w_mix      = sat_mix(w_mix_wide);
`else
  assign w_mix = MIX_W'(w_acc_mo) + (MIX_W'(w_acc_ro) <<< 1);
`endif

  // The CYCLE_00 slot always starts a new frame, so it loads rather than adds.
  ikaopll_sat_acc u_acc_mo (
    .clk_i   (i_EMUCLK),
    .rst_n_i (i_IC_n),
    .en_i    (w_en),
    .load_i  (i_CYCLE_00),
    .add_i   (state_q == ACCUM),
    .term_i  (w_cm),
    .acc_o   (w_acc_mo)
  );

  ikaopll_sat_acc u_acc_ro (
    .clk_i   (i_EMUCLK),
    .rst_n_i (i_IC_n),
    .en_i    (w_en),
    .load_i  (i_CYCLE_00),
    .add_i   (state_q == ACCUM),
    .term_i  (w_cr),
    .acc_o   (w_acc_ro)
  );

  always_comb begin
    state_d = state_q;
    if (w_en && i_CYCLE_00)
      state_d = ACCUM;
  end

  always_ff @(posedge i_EMUCLK) begin
    if (!i_IC_n) begin
      state_q <= WAIT_SYNC;
      mo_q    <= '0;
      ro_q    <= '0;
      mix_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_dump) begin
        mo_q    <= w_acc_mo;
        ro_q    <= w_acc_ro;
        mix_q   <= OUT_WIDTH'(w_mix);
        valid_q <= 1'b1;
        if (valid_q && !i_SAMPLE_ACK)
          ovr_q <= 1'b1;
      end else if (i_SAMPLE_ACK) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_MO           = mo_q;
  assign o_RO           = ro_q;
  assign o_MIX          = mix_q;
  assign o_SAMPLE_VALID = valid_q;
  assign o_OVERRUN      = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_ikaopll_sample_accumulator.sv
// +------------------------------------------------------------------+
// | tb_ikaopll_sample_accumulator : directed self-checking bench for  |
// | ikaopll_sample_accumulator (both IKAOPLL_ACC_SATURATE_EN builds). |
// +------------------------------------------------------------------+
`default_nettype none

module tb_ikaopll_sample_accumulator;

  logic              clk = 1'b0;
  logic              ic_n = 1'b0;
  logic              ncen_n = 1'b1;
  logic              cyc = 1'b0;
  logic              mo_ctrl = 1'b0;
  logic              ro_ctrl = 1'b0;
  logic              rhy_en = 1'b0;
  logic [8:0]        op = '0;
  logic              ack = 1'b0;
  logic signed [12:0] mo;
  logic signed [12:0] ro;
  logic signed [15:0] mix;
  logic              valid;
  logic              ovr;

  int n_chk = 0;
  int n_err = 0;

  ikaopll_sample_accumulator #(.OUT_WIDTH(16)) dut (
    .i_EMUCLK       (clk),
    .i_IC_n         (ic_n),
    .i_phi1_NCEN_n  (ncen_n),
    .i_CYCLE_00     (cyc),
    .i_MO_CTRL      (mo_ctrl),
    .i_RO_CTRL      (ro_ctrl),
    .i_RHYTHM_EN    (rhy_en),
    .i_OP_OUT       (op),
    .i_SAMPLE_ACK   (ack),
    .o_MO           (mo),
    .o_RO           (ro),
    .o_MIX          (mix),
    .o_SAMPLE_VALID (valid),
    .o_OVERRUN      (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One enabled edge with the given terms, then a disabled edge carrying
  // junk controls that must be ignored.
  task automatic slot(input logic c, input logic m, input logic r,
                      input int v, input logic a);
    @(negedge clk);
    ncen_n = 1'b0; cyc = c; mo_ctrl = m; ro_ctrl = r; op = 9'(v); ack = a;
    @(posedge clk);
    @(negedge clk);
    ncen_n = 1'b1; cyc = 1'b1; mo_ctrl = 1'b1; ro_ctrl = 1'b1; op = 9'h0FF; ack = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic empties(input int n);
    for (int i = 0; i < n; i++) slot(1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    ncen_n = 1'b1; cyc = 1'b0; ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    ic_n = 1'b0; ncen_n = 1'b0; cyc = 1'b1; mo_ctrl = 1'b1; op = 9'd50; ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ic_n = 1'b1; ncen_n = 1'b1; cyc = 1'b0; mo_ctrl = 1'b0; ro_ctrl = 1'b0; ack = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();
    check("rst_mo", mo, 0);
    check("rst_ro", ro, 0);
    check("rst_mix", mix, 0);
    check("rst_valid", valid, 0);
    check("rst_ovr", ovr, 0);

    // Melody frame: 9 x +100
    slot(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check("first_sync_no_valid", valid, 0);
    for (int i = 0; i < 9; i++) slot(1'b0, 1'b1, 1'b0, 100, 1'b0);
    empties(8);
    slot(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check("mel_mo", mo, 900);
    check("mel_ro", ro, 0);
    check("mel_mix", mix, 900);
    check("mel_valid", valid, 1);
    ack_pulse();
    check("ack_clears_valid", valid, 0);

    // Rhythm frame: 5 x -50
    rhy_en = 1'b1;
    for (int i = 0; i < 5; i++) slot(1'b0, 1'b0, 1'b1, -50, 1'b0);
    empties(12);
    slot(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check("rhy_mo", mo, 0);
    check("rhy_ro", ro, -250);
    check("rhy_mix", mix, -500);
    ack_pulse();

    // Rhythm disabled
    rhy_en = 1'b0;
    for (int i = 0; i < 5; i++) slot(1'b0, 1'b0, 1'b1, -50, 1'b0);
    empties(12);
    slot(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check("rhyoff_ro", ro, 0);
    check("rhyoff_mix", mix, 0);
    check("rhyoff_valid", valid, 1);
    check("rhyoff_ovr", ovr, 0);

    // Dump and ack on the same edge
    empties(17);
    slot(1'b1, 1'b0, 1'b0, 0, 1'b1);
    check("same_edge_valid", valid, 1);
    check("same_edge_ovr", ovr, 0);

    // Unacknowledged dump overruns; CYCLE_00 slot carries +7 into new frame
    empties(17);
    slot(1'b1, 1'b1, 1'b0, 7, 1'b0);
    check("ovr_set", ovr, 1);
    check("ovr_mo", mo, 0);
    ack_pulse();
    check("ovr_ack_valid", valid, 0);
    check("ovr_sticky", ovr, 1);
    empties(17);
    slot(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check("sync_slot_mo", mo, 7);
    check("sync_slot_valid", valid, 1);
    check("ovr_sticky2", ovr, 1);
    ack_pulse();

    // 20 x 255 on both lanes: wrap versus clamp
    rhy_en = 1'b1;
    for (int i = 0; i < 20; i++) slot(1'b0, 1'b1, 1'b1, 255, 1'b0);
    slot(1'b1, 1'b0, 1'b0, 0, 1'b0);
`ifdef IKAOPLL_ACC_SATURATE_EN
    check("big_mo", mo, 4095);
    check("big_ro", ro, 4095);
    check("big_mix", mix, 8191);
`else
    check("big_mo", mo, -3092);
    check("big_ro", ro, -3092);
    check("big_mix", mix, 7108);
`endif
    ack_pulse();

    // Back-to-back CYCLE_00: second dump holds only the first edge's term
    slot(1'b1, 1'b1, 1'b0, 5, 1'b0);
    check("b2b_first_mo", mo, 0);
    slot(1'b1, 1'b1, 1'b0, 3, 1'b0);
    check("b2b_second_mo", mo, 5);
    empties(3);
    slot(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check("b2b_third_mo", mo, 3);

    // Reset mid-frame
    slot(1'b0, 1'b1, 1'b0, 10, 1'b0);
    slot(1'b0, 1'b1, 1'b0, 10, 1'b0);
    do_reset();
    check("midrst_mo", mo, 0);
    check("midrst_mix", mix, 0);
    check("midrst_valid", valid, 0);
    check("midrst_ovr", ovr, 0);
    slot(1'b0, 1'b1, 1'b0, 10, 1'b0);
    slot(1'b0, 1'b1, 1'b0, 10, 1'b0);
    slot(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check("postrst_sync_valid", valid, 0);
    check("postrst_sync_mo", mo, 0);
    for (int i = 0; i < 3; i++) slot(1'b0, 1'b1, 1'b0, 10, 1'b0);
    slot(1'b1, 1'b0, 1'b0, 0, 1'b0);
    check("postrst_mo", mo, 30);
    check("postrst_valid", valid, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
